// File: rtl/regfile_32x64.sv
// -----------------------------------------------------------------------------
// regfile_32x64 : architectural integer register file, 32 x WIDTH.
//   One synchronous write port, two combinational read ports.
//   Register ZERO_REG always reads 0 and discards writes (it has no storage).
//
// Ports
//   clk            : system clock, all state updates on rising edge
//   rst_n          : synchronous active-low reset, clears every register
//   RegWrite       : write enable
//   WriteRegister  : destination register index (5 bits)
//   WriteData      : data to write (WIDTH bits)
//   ReadRegister1  : read port 1 index
//   ReadRegister2  : read port 2 index
//   ReadData1      : read port 1 data (combinational)
//   ReadData2      : read port 2 data (combinational)
//
// Optional feature
//   REGFILE_BYPASS_EN : when defined, a read of the index being written this
//   cycle returns WriteData combinationally (write-first forwarding), per port.
//   Never forwarded for ZERO_REG or while rst_n is low.
// -----------------------------------------------------------------------------
module regfile_32x64 #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             RegWrite,
   input  logic [4:0]       WriteRegister,
   input  logic [WIDTH-1:0] WriteData,
   input  logic [4:0]       ReadRegister1,
   input  logic [4:0]       ReadRegister2,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2
);

   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   // Word view of storage; the zero register is a constant.
   logic [WIDTH-1:0] word_view_c [NREGS];

   // Bit-transposed view: col_c[b][i] = reg[i][b], the inputs of bit-slice b's 32:1 mux.
   logic [NREGS-1:0] col_c [WIDTH];

   logic [WIDTH-1:0] rd1_mux_c;
   logic [WIDTH-1:0] rd2_mux_c;

   // Storage words with their slice of the 5:32 one-hot write decoder.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_word
      if (gi == ZERO_REG) begin : g_zero
         assign word_view_c[gi] = '0;
      end else begin : g_dff
         logic             we_c;
         logic [WIDTH-1:0] word_d;
         logic [WIDTH-1:0] word_q;

         // Pure AND of static inputs: at most one word enabled per edge.
         assign we_c = RegWrite & rst_n & (WriteRegister == AW'(gi));

         always_comb begin
            word_d = word_q;
            if (we_c) begin
               word_d = WriteData;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               word_q <= '0;
            end else begin
               word_q <= word_d;
            end
         end

         assign word_view_c[gi] = word_q;
      end
   end

   // Transpose storage into per-bit mux input vectors.
   always_comb begin
      for (int b = 0; b < WIDTH; b++) begin
         col_c[b] = '0;
         for (int i = 0; i < NREGS; i++) begin
            col_c[b][i] = word_view_c[i][b];
         end
      end
   end

   // WIDTH bit-slices of a 32:1 one-bit mux per read port.
   always_comb begin
      rd1_mux_c = '0;
      rd2_mux_c = '0;
      for (int b = 0; b < WIDTH; b++) begin
         rd1_mux_c[b] = col_c[b][ReadRegister1];
         rd2_mux_c[b] = col_c[b][ReadRegister2];
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic wr_fwd_ok_c;
   logic byp1_c;
   logic byp2_c;

   // Forwarding only for a live, non-zero-register write.
   assign wr_fwd_ok_c = RegWrite & rst_n & (WriteRegister != AW'(ZERO_REG));
   assign byp1_c      = wr_fwd_ok_c & (ReadRegister1 == WriteRegister);
   assign byp2_c      = wr_fwd_ok_c & (ReadRegister2 == WriteRegister);

   assign ReadData1 = byp1_c ? WriteData : rd1_mux_c;
   assign ReadData2 = byp2_c ? WriteData : rd2_mux_c;
`else
   assign ReadData1 = rd1_mux_c;
   assign ReadData2 = rd2_mux_c;
`endif

endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- Architectural integer register file for the single-cycle/pipelined CPU. It holds 32 registers; X31 is hardwired to zero.
- One synchronous write port and two read ports.
- Storage is built from DFF words behind a 5:32 write decoder.
- Each read port is WIDTH bit-slices of the team's 32:1 one-bit mux, fed by a bit-transposed view of the storage. This block is the stage that produces those mux inputs.

Parameters:
- WIDTH, 64, data width of each register and of each read/write data port.
- ZERO_REG, 31, index of the register that always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- RegWrite  input  1  write enable
- WriteRegister  input  5  destination register index
- WriteData  input  WIDTH  data to write
- ReadRegister1  input  5  read port 1 index
- ReadRegister2  input  5  read port 2 index
- ReadData1  output  WIDTH  read port 1 data
- ReadData2  output  WIDTH  read port 2 data

Behaviour:
- Interface: one clock, clk. Reset is rst_n: synchronous, active-low.
- Reset:
  - On a rising edge with rst_n=0, all 32 registers clear to 0 in that single cycle.
  - RegWrite is ignored on a reset edge, even when asserted.
  - ReadData1/2 read 0 from the first edge with rst_n=0 until the first post-reset write.
  - Before the first reset edge, register contents are undefined; the bench must not check them.
- Write:
  - On a rising edge with rst_n=1 and RegWrite=1, reg[WriteRegister] <= WriteData.
  - Latency: the value is visible on the read ports after that edge (same-cycle visibility only with the bypass, see Optional Feature).
  - Writes to ZERO_REG are discarded; reg[31] stays 0 at all times.
  - RegWrite=0 leaves every register unchanged.
- Write decoder:
  - 5:32 one-hot, gated by RegWrite and rst_n.
  - Exactly one word, or none, is enabled per edge. A glitch-free decode is required; no latch inference.
- Read:
  - Combinational, zero-cycle. ReadDataN = reg[ReadRegisterN].
  - Data bit b of port N comes from a 32:1 mux whose input i is reg[i][b], with sel = ReadRegisterN.
  - Both ports may address the same register simultaneously, including ZERO_REG and the register being written.
- Simultaneous write + read of the same index (no bypass): the read port shows the OLD value until the edge, then the new value.
- Register 31 storage may be optimised to constant 0, but the read path must still return 0 for index 31.
- Reset mid-operation: a reset edge during any write sequence clears everything. The write on that edge is lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When RegWrite=1, rst_n=1, WriteRegister!=ZERO_REG and ReadRegisterN==WriteRegister, ReadDataN = WriteData combinationally in the same cycle (write-first forwarding).
  - Applies independently to each port.
  - No bypass when the index is ZERO_REG or while rst_n=0; in those cases the port reads 0 or the stored value as usual.
- Undefined: no forwarding; reads always return stored contents (read-old-value on same-index collisions).

Test Plan:
- Reset then read: hold rst_n=0 for 1 edge with RegWrite=1, WriteRegister=5, WriteData=64'hDEAD; release. ReadRegister1=5, ReadRegister2=0 -> both ReadData = 0.
- Write all registers: for i=0..30, write 64'h0101_0101_0000_0000+i. Then sweep ReadRegister1=i and ReadRegister2=30-i -> each port returns its programmed value. Index 31 -> 0.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to index 31. Read 31 on both ports -> 0 before and after the edge.
- Write disable: RegWrite=0 with WriteRegister=7, WriteData=64'h1234 -> reg7 keeps its prior value 64'h0101_0101_0000_0007.
- Same-index collision: reg3=64'hAAAA. In one cycle set RegWrite=1, WriteRegister=3, WriteData=64'h5555, ReadRegister1=3.
  - Without macro: 64'hAAAA before the edge, 64'h5555 after.
  - With REGFILE_BYPASS_EN: 64'h5555 immediately.
- Mid-run reset: after the writes above, pulse rst_n=0 for one edge while writing reg9 -> all reads 0 afterwards, including reg9.
